// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus bundle: program memory read port, instruction handshake, redirect.
interface instr_fetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_strobe;
  logic [7:0]            mem_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [23:0]           instr_bytes;
  logic [1:0]            instr_len;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_addr;

  // Fetch queue side
  modport master (
    output mem_addr, mem_strobe, instr_valid, instr_bytes, instr_len, instr_pc,
    input  mem_data, instr_ready, redirect, redirect_addr
  );

  // Memory / execute-stage side
  modport slave (
    input  mem_addr, mem_strobe, instr_valid, instr_bytes, instr_len, instr_pc,
    output mem_data, instr_ready, redirect, redirect_addr
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Prefetching instruction byte queue: streams program memory at one byte per
// clock, decodes opcode length and hands whole 1/2/3-byte instructions to execute.
module instr_fetch_queue #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  instr_fetch_queue_if.master    bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]            r_queue [DEPTH];
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_head_pc;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic                  r_pending;
  logic                  r_discard;

  logic [7:0]            w_b0;
  logic [7:0]            w_b1;
  logic [7:0]            w_b2;
  logic [1:0]            w_len;
  logic                  w_valid;
  logic                  w_strobe;
  logic                  w_capture;
  logic                  w_pop;
  logic [CW-1:0]         w_pop_len;

  // Head decode, handshake qualification and issue decision
  always_comb begin
    w_b0 = r_queue[r_rd_ptr];
    w_b1 = r_queue[r_rd_ptr + PW'(1)];
    w_b2 = r_queue[r_rd_ptr + PW'(2)];
    w_len = 2'd2;
    case (w_b0[3:0])
      4'hE, 4'hF:                      w_len = 2'd1;
      4'h4, 4'h5, 4'h6, 4'h7, 4'hD:    w_len = 2'd3;
      default:                         w_len = 2'd2;
    endcase
    w_valid   = (r_count != '0) && (r_count >= CW'(w_len));
    w_pop     = w_valid && bus.instr_ready;
    w_pop_len = w_pop ? CW'(w_len) : '0;
    // Occupied slots plus the byte in flight must leave room for one more
    w_strobe  = reset_n && ((r_count + CW'(r_pending)) < CW'(DEPTH)) && !bus.redirect;
    w_capture = r_pending && !r_discard;
  end

  // Fetch/head pointers, occupancy and byte storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= ADDR_WIDTH'(RESET_PC);
      r_head_pc  <= ADDR_WIDTH'(RESET_PC);
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_pending  <= 1'b0;
      r_discard  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) r_queue[i] <= '0;
    end else if (bus.redirect) begin
      // Flush; a read already in flight is dropped on return
      r_fetch_pc <= bus.redirect_addr;
      r_head_pc  <= bus.redirect_addr;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_pending  <= 1'b0;
      r_discard  <= r_pending;
    end else begin
      r_pending <= w_strobe;
      r_discard <= 1'b0;
      if (w_strobe) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(1);
      if (w_capture) begin
        r_queue[r_wr_ptr] <= bus.mem_data;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PW'(w_len);
        r_head_pc <= r_head_pc + ADDR_WIDTH'(w_len);
      end
      r_count <= r_count + CW'(w_capture) - w_pop_len;
    end
  end

  assign bus.mem_addr    = r_fetch_pc;
  assign bus.mem_strobe  = w_strobe;
  assign bus.instr_valid = w_valid;
  assign bus.instr_len   = w_len;
  assign bus.instr_pc    = r_head_pc;
  assign bus.instr_bytes = {w_b0,
                            (w_len >= 2'd2) ? w_b1 : 8'h00,
                            (w_len == 2'd3) ? w_b2 : 8'h00};

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a synchronous memory model and an
// expected-instruction scoreboard checked on every accepted transfer.
module tb_instr_fetch_queue;

  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [7:0]  pc;
    logic [1:0]  len;
    logic [23:0] bytes;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [7:0] mem [256];
  logic [7:0] mem_q = 8'h00;
  int strobe_cnt = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb[$];

  instr_fetch_queue_if #(.ADDR_WIDTH(AW)) bus ();

  instr_fetch_queue #(.ADDR_WIDTH(AW), .DEPTH(4), .RESET_PC(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous program memory: data returned the cycle after the strobe
  always @(posedge clk) begin
    if (bus.mem_strobe) begin
      mem_q      <= mem[bus.mem_addr];
      strobe_cnt <= strobe_cnt + 1;
    end
  end
  assign bus.mem_data = mem_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] len_of(input logic [7:0] op);
    case (op[3:0])
      4'hE, 4'hF:                   return 2'd1;
      4'h4, 4'h5, 4'h6, 4'h7, 4'hD: return 2'd3;
      default:                      return 2'd2;
    endcase
  endfunction

  task automatic push(input logic [7:0] pc, input logic [1:0] len, input logic [23:0] bytes);
    exp_t e;
    e.pc = pc; e.len = len; e.bytes = bytes;
    sb.push_back(e);
  endtask

  // Walk the memory image from start, queueing n expected instructions
  task automatic push_model(input logic [7:0] start, input int n);
    logic [7:0] pc;
    logic [1:0] l;
    logic [7:0] b1, b2;
    pc = start;
    for (int i = 0; i < n; i++) begin
      l  = len_of(mem[pc]);
      b1 = (l >= 2'd2) ? mem[pc + 8'd1] : 8'h00;
      b2 = (l == 2'd3) ? mem[pc + 8'd2] : 8'h00;
      push(pc, l, {mem[pc], b1, b2});
      pc = pc + 8'(l);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Every accepted instruction must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n && bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("instr_pc", 32'(bus.instr_pc), 32'(e.pc));
        chk("instr_len", 32'(bus.instr_len), 32'(e.len));
        chk("instr_bytes", 32'(bus.instr_bytes), 32'(e.bytes));
      end
    end
  end

  task automatic assert_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b0;
    #1;
    chk("rst_strobe", 32'(bus.mem_strobe), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset(input logic rdy);
    bus.instr_ready = rdy;
    reset_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    int cyc;
    cyc = 0;
    bus.instr_ready = 1'b1;
    while (sb.size() != 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.instr_ready = 1'b0;
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bus.instr_ready   = 1'b0;
    bus.redirect      = 1'b0;
    bus.redirect_addr = '0;
    reset_n = 1'b0;

    // 1: single-byte opcodes streamed straight from reset
    assert_reset();
    fill(8'hFF);
    push(8'h00, 2'd1, 24'hFF0000);
    push(8'h01, 2'd1, 24'hFF0000);
    push(8'h02, 2'd1, 24'hFF0000);
    release_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_strobe", 32'(bus.mem_strobe), 32'd1);
      chk("t1_addr", 32'(bus.mem_addr), 32'(i));
      @(posedge clk); #1;
    end
    drain("t1_drain", 20);

    // 2: mixed 2/3-byte instructions
    assert_reset();
    fill(8'hFF);
    mem[0] = 8'h0C; mem[1] = 8'h55;
    mem[2] = 8'h16; mem[3] = 8'h03; mem[4] = 8'h7F;
    mem[5] = 8'h8D; mem[6] = 8'h12; mem[7] = 8'h34;
    push(8'h00, 2'd2, 24'h0C5500);
    push(8'h02, 2'd3, 24'h16037F);
    push(8'h05, 2'd3, 24'h8D1234);
    release_reset(1'b1);
    drain("t2_drain", 40);

    // 3: stall until full, then resume without loss or duplication
    assert_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    push_model(8'h00, 12);
    base = strobe_cnt;
    release_reset(1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t3_valid_a", 32'(bus.instr_valid), 32'd1);
    chk("t3_pc_a", 32'(bus.instr_pc), 32'(sb[0].pc));
    chk("t3_bytes_a", 32'(bus.instr_bytes), 32'(sb[0].bytes));
    repeat (10) @(posedge clk);
    #1;
    chk("t3_strobes", 32'(strobe_cnt - base), 32'd4);
    @(negedge clk);
    chk("t3_full_nostrobe", 32'(bus.mem_strobe), 32'd0);
    chk("t3_valid_b", 32'(bus.instr_valid), 32'd1);
    chk("t3_len_b", 32'(bus.instr_len), 32'(sb[0].len));
    chk("t3_bytes_b", 32'(bus.instr_bytes), 32'(sb[0].bytes));
    @(posedge clk); #1;
    drain("t3_drain", 100);

    // 4: redirect the cycle after the strobe to 0x05
    assert_reset();
    fill(8'hFF);
    mem[8'h40] = 8'hFE;
    for (int i = 0; i < 5; i++) push(8'(i), 2'd1, 24'hFF0000);
    push(8'h40, 2'd1, 24'hFE0000);
    release_reset(1'b1);
    begin
      int cyc;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(bus.mem_strobe && bus.mem_addr == 8'h05) && cyc < 20);
      chk("t4_saw_strobe5", 32'(bus.mem_addr), 32'h05);
    end
    @(posedge clk); #1;
    bus.redirect = 1'b1;
    bus.redirect_addr = 8'h40;
    @(negedge clk);
    chk("t4_redir_nostrobe", 32'(bus.mem_strobe), 32'd0);
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    @(negedge clk);
    chk("t4_n1_strobe", 32'(bus.mem_strobe), 32'd1);
    chk("t4_n1_addr", 32'(bus.mem_addr), 32'h40);
    chk("t4_n1_valid", 32'(bus.instr_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_n2_valid", 32'(bus.instr_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_n3_valid", 32'(bus.instr_valid), 32'd1);
    chk("t4_n3_pc", 32'(bus.instr_pc), 32'h40);
    @(posedge clk); #1;
    drain("t4_drain", 10);

    // 5: instruction straddling the address wrap
    assert_reset();
    fill(8'hFF);
    mem[8'hFE] = 8'hD6; mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
    release_reset(1'b0);
    repeat (8) @(posedge clk);
    #1;
    bus.redirect = 1'b1;
    bus.redirect_addr = 8'hFE;
    @(negedge clk);
    chk("t5_redir_nostrobe", 32'(bus.mem_strobe), 32'd0);
    @(posedge clk); #1;
    bus.redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] a;
      a = 8'hFE + 8'(i);
      @(negedge clk);
      chk("t5_strobe", 32'(bus.mem_strobe), 32'd1);
      chk("t5_addr", 32'(bus.mem_addr), 32'(a));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t5_full_nostrobe", 32'(bus.mem_strobe), 32'd0);
    chk("t5_valid", 32'(bus.instr_valid), 32'd1);
    push(8'hFE, 2'd3, 24'hD61234);
    @(posedge clk); #1;
    drain("t5_drain", 10);

    // 6: reset with a read in flight; stale byte must not appear
    assert_reset();
    fill(8'hAA);
    release_reset(1'b0);
    @(posedge clk); #1;
    chk("t6_pending_cycle_strobe", 32'(bus.mem_strobe), 32'd1);
    assert_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 13 + 5);
    push_model(8'h00, 6);
    release_reset(1'b0);
    @(negedge clk);
    chk("t6_restart_addr", 32'(bus.mem_addr), 32'd0);
    @(posedge clk); #1;
    drain("t6_drain", 60);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
